// File: rtl/config_master_fsm.sv
// config_master_fsm: initiator side of the UART auto-configuration handshake.
// Ports: clk_i, rst_n_i (sync, active-low); start_i/config_i request;
//   rx_fifo_empty_i/rx_data_i/rx_fifo_read_o ack input;
//   tx_fifo_full_i/tx_fifo_write_o/tx_data_o packet output;
//   config_o/config_en_o commit; std_config_o/config_error_o on failure;
//   busy_o/data_stream_mode_o while handshaking.
// Macro CONFIG_MASTER_RETRY_EN: data-phase timeouts resend instead of failing.
module config_master_fsm #(
  parameter int unsigned TIMEOUT_CYCLES = 2_500_000,
  parameter int unsigned MAX_RETRIES    = 3
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       start_i,
  input  logic [5:0] config_i,
  input  logic       rx_fifo_empty_i,
  input  logic [7:0] rx_data_i,
  output logic       rx_fifo_read_o,
  input  logic       tx_fifo_full_i,
  output logic       tx_fifo_write_o,
  output logic [7:0] tx_data_o,
  output logic       data_stream_mode_o,
  output logic       busy_o,
  output logic [5:0] config_o,
  output logic       config_en_o,
  output logic       std_config_o,
  output logic       config_error_o
);

  localparam int unsigned CW =
    (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0] RETRY_LIM = 3'(MAX_RETRIES);

`ifdef CONFIG_MASTER_RETRY_EN
  localparam logic DATA_RETRY = 1'b1;
`else
  localparam logic DATA_RETRY = 1'b0;
`endif

  localparam logic [7:0] PKT_REQ = 8'hF0;
  localparam logic [7:0] PKT_ACK = 8'hFF;
  localparam logic [7:0] PKT_DW  = 8'hC0;
  localparam logic [7:0] PKT_PM  = 8'hC4;
  localparam logic [7:0] PKT_SB  = 8'hC8;
  localparam logic [7:0] PKT_END = 8'hCC;

  typedef enum logic [3:0] {
    IDLE, SEND_REQ, WAIT_REQ, SEND_DW, WAIT_DW,
    SEND_PM, WAIT_PM, SEND_SB, WAIT_SB,
    SEND_END, WAIT_END, DONE, FAIL
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    retry_q, retry_d;
  logic [5:0]    cfg_q, cfg_d;

  state_e        next_s, resend_s;
  logic          is_send, is_wait, can_retry;
  logic [7:0]    pkt;
  logic [CW-1:0] cnt_inc;
  logic [2:0]    retry_inc;
  logic          timeout;
  logic          ack;

  // Saturating counters; the timeout fires in the cycle the count reaches
  // its last value, so a resend lands TIMEOUT_CYCLES after the prior write.
  assign cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CW'(1);
  assign timeout   = (cnt_inc >= CNT_LAST);
  assign retry_inc = (retry_q == 3'd7) ? retry_q : retry_q + 3'd1;
  assign ack       = !rx_fifo_empty_i && (rx_data_i == PKT_ACK);

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    retry_d         = retry_q;
    cfg_d           = cfg_q;
    next_s          = IDLE;
    resend_s        = IDLE;
    is_send         = 1'b0;
    is_wait         = 1'b0;
    can_retry       = 1'b0;
    pkt             = 8'h00;
    rx_fifo_read_o  = 1'b0;
    tx_fifo_write_o = 1'b0;
    tx_data_o       = 8'h00;
    config_en_o     = 1'b0;
    std_config_o    = 1'b0;
    config_error_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          cfg_d   = config_i;
          retry_d = '0;
          state_d = SEND_REQ;
        end
      end
      SEND_REQ: begin
        is_send = 1'b1;
        pkt     = PKT_REQ;
        next_s  = WAIT_REQ;
      end
      WAIT_REQ: begin
        is_wait   = 1'b1;
        next_s    = SEND_DW;
        resend_s  = SEND_REQ;
        can_retry = 1'b1;
      end
      SEND_DW: begin
        is_send = 1'b1;
        pkt     = PKT_DW | {6'b0, cfg_q[5:4]};
        next_s  = WAIT_DW;
      end
      WAIT_DW: begin
        is_wait   = 1'b1;
        next_s    = SEND_PM;
        resend_s  = SEND_DW;
        can_retry = DATA_RETRY;
      end
      SEND_PM: begin
        is_send = 1'b1;
        pkt     = PKT_PM | {6'b0, cfg_q[3:2]};
        next_s  = WAIT_PM;
      end
      WAIT_PM: begin
        is_wait   = 1'b1;
        next_s    = SEND_SB;
        resend_s  = SEND_PM;
        can_retry = DATA_RETRY;
      end
      SEND_SB: begin
        is_send = 1'b1;
        pkt     = PKT_SB | {6'b0, cfg_q[1:0]};
        next_s  = WAIT_SB;
      end
      WAIT_SB: begin
        is_wait   = 1'b1;
        next_s    = SEND_END;
        resend_s  = SEND_SB;
        can_retry = DATA_RETRY;
      end
      SEND_END: begin
        is_send = 1'b1;
        pkt     = PKT_END;
        next_s  = WAIT_END;
      end
      WAIT_END: begin
        is_wait   = 1'b1;
        next_s    = DONE;
        resend_s  = SEND_END;
        can_retry = DATA_RETRY;
      end
      DONE: begin
        config_en_o = 1'b1;
        state_d     = IDLE;
      end
      FAIL: begin
        std_config_o   = 1'b1;
        config_error_o = 1'b1;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (is_send) begin
      tx_data_o = pkt;
      if (!tx_fifo_full_i) begin
        tx_fifo_write_o = 1'b1;
        cnt_d           = '0;
        state_d         = next_s;
      end
    end

    // An acknowledge in the timeout cycle still wins.
    if (is_wait) begin
      cnt_d          = cnt_inc;
      rx_fifo_read_o = !rx_fifo_empty_i;
      if (ack) begin
        state_d = next_s;
      end else if (timeout) begin
        if (can_retry) begin
          retry_d = retry_inc;
          state_d = (retry_inc < RETRY_LIM) ? resend_s : FAIL;
        end else begin
          state_d = FAIL;
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      retry_q <= '0;
      cfg_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      cfg_q   <= cfg_d;
    end
  end

  assign busy_o             = (state_q != IDLE);
  assign data_stream_mode_o = busy_o;
  assign config_o           = cfg_q;

endmodule

// File: doc/config_master_fsm.md
# config_master_fsm

Initiator side of the UART automatic-configuration handshake. Sits beside the main controller. On a master configuration request it:
- sends a request packet and waits for an acknowledge,
- pushes the data-width, parity-mode and stop-bit packets in turn, each gated by an acknowledge from the slave,
- closes with an end-of-configuration packet,
- on success, commits the new configuration to the configuration register; on failure, asks for the standard configuration and flags a configuration error.

## Interface
- TIMEOUT_CYCLES, 2_500_000, acknowledge timeout in clk_i cycles (50 ms at 50 MHz).
- MAX_RETRIES, 3, total request attempts before failure (range 1..7).
- clk_i  in  1  system clock
- rst_n_i  in  1  reset. One clock; reset is synchronous and active-low.
- start_i  in  1  configuration request from CPU side; sampled only in IDLE
- config_i  in  6  uart_config_s {data_width[1:0], parity_mode[1:0], stop_bits[1:0]}; latched on accepted start
- rx_fifo_empty_i  in  1  RX FIFO empty
- rx_data_i  in  8  RX FIFO head (first-word-fall-through)
- rx_fifo_read_o  out  1  pop RX FIFO
- tx_fifo_full_i  in  1  TX FIFO full
- tx_fifo_write_o  out  1  push tx_data_o
- tx_data_o  out  8  packet to transmit
- data_stream_mode_o  out  1  suppress per-byte RX interrupts while busy
- busy_o  out  1  FSM not in IDLE
- config_o  out  6  latched configuration to commit
- config_en_o  out  1  one-cycle commit strobe for config_o
- std_config_o  out  1  one-cycle request to load the standard configuration
- config_error_o  out  1  one-cycle configuration-error pulse

## Operation
- Packet format: id in bits [7:2], option in bits [1:0].
  - REQ = 8'hF0
  - ACKN_PKT = 8'hFF
  - DW = 8'hC0|data_width
  - PM = 8'hC4|parity_mode
  - SB = 8'hC8|stop_bits
  - END = 8'hCC
- States: IDLE, SEND_REQ, WAIT_REQ, SEND_DW, WAIT_DW, SEND_PM, WAIT_PM, SEND_SB, WAIT_SB, SEND_END, WAIT_END, DONE, FAIL.
- IDLE: start_i=1 latches config_i, clears the retry count, and moves to SEND_REQ.
- SEND_x: while tx_fifo_full_i=0, assert tx_fifo_write_o with the packet for one cycle, clear the timeout counter, and go to WAIT_x. While tx_fifo_full_i=1, stall with no write.
- WAIT_x:
  - The counter increments every cycle.
  - If rx_fifo_empty_i=0, assert rx_fifo_read_o for one cycle.
  - If the popped byte equals ACKN_PKT, go to the next SEND state (WAIT_END goes to DONE).
  - Any other byte is discarded and waiting continues.
- Timeout: counter reaches TIMEOUT_CYCLES-1 with no acknowledge.
  - WAIT_REQ: increment the retry count. If the count is below MAX_RETRIES, go to SEND_REQ; otherwise go to FAIL.
  - WAIT_DW/PM/SB/END: see Configuration.
- DONE: pulse config_en_o (config_o valid) for one cycle, then go to IDLE.
- FAIL: pulse config_error_o and std_config_o for one cycle, then go to IDLE.
- data_stream_mode_o = busy_o = (state != IDLE).

## Timing
- Reset values:
  - state is IDLE.
  - All outputs are 0, including config_o = 6'b0.
  - The counter and the retry count are 0.
- start_i to the first tx_fifo_write_o is 2 cycles (IDLE→SEND_REQ, SEND_REQ writes) when the TX FIFO is not full.
- An acknowledge visible in cycle N moves the FSM to the next SEND in N+1; the write happens in N+1.
- An acknowledge and a timeout in the same cycle: the acknowledge wins.
- start_i while busy is ignored; there is no queueing.
- An acknowledge seen in SEND_x or IDLE is not popped.
- The counter is $clog2(TIMEOUT_CYCLES) bits wide and saturates; it never wraps.
- Reset mid-handshake returns to IDLE next cycle with no commit and no error pulse.

## Configuration
- Macro: CONFIG_MASTER_RETRY_EN.
- Defined: a timeout in WAIT_DW/PM/SB/END resends the same packet.
  - These retries share the retry count with the request phase.
  - The count is not cleared between phases.
  - FAIL is entered once the count reaches MAX_RETRIES.
- Undefined: any timeout in WAIT_DW/PM/SB/END goes to FAIL immediately. Retries apply only to the request phase.

## Test plan
All scenarios use TIMEOUT_CYCLES=16 and MAX_RETRIES=3.
- Nominal: start_i with config_i=6'b11_01_00 and each acknowledge returned 3 cycles after its write → TX sequence F0, C3, C5, C8, CC; one config_en_o pulse with config_o=6'b11_01_00; config_error_o never asserted.
- No slave: start_i with no RX traffic → exactly 3 writes of F0, 16 cycles apart; then config_error_o=1 and std_config_o=1 for one cycle; busy_o=0 the next cycle.
- Noise: byte 8'h55 arrives in WAIT_DW, then 8'hFF → 8'h55 popped and ignored; C4|pm is sent after FF.
- Backpressure: tx_fifo_full_i=1 for 10 cycles during SEND_PM → no write while full; single write the cycle after full deasserts; timeout counting starts only after that write.
- Data-phase timeout: SB never acknowledged → without the macro, FAIL 16 cycles after the C8 write; with CONFIG_MASTER_RETRY_EN, C8 is resent until the shared retry count reaches 3, then FAIL.
- Reset mid-WAIT_PM → IDLE, all outputs 0, no config_en_o, no config_error_o.
